// File: rtl/mult_seq_pkg.sv
// Shared types and constants for the multiplier job sequencer:
// operand/product widths, the sequencer FSM state type, the packed
// FIFO entry and the default phase/timeout lengths.
package mult_seq_pkg;

  localparam int OP_W             = 6;
  localparam int PROD_W           = 12;
  localparam int DEF_START_CYCLES = 2;
  localparam int DEF_TIMEOUT      = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } seq_state_t;

  // One queued multiplication: multiplicand in the upper half.
  typedef struct packed {
    logic [OP_W-1:0] x;
    logic [OP_W-1:0] y;
  } job_t;

  function automatic job_t pack_job(input logic [OP_W-1:0] x,
                                    input logic [OP_W-1:0] y);
    job_t j;
    j.x = x;
    j.y = y;
    return j;
  endfunction

endpackage

// File: rtl/mult_seq_fifo.sv
// Operand FIFO for the job sequencer. DEPTH entries of W bits,
// registered storage, read data shows the head entry combinationally.
// Full/empty come from read/write pointers carrying one extra wrap bit.
// A push while full is taken only when a pop happens in the same cycle.
module mult_seq_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // Pointer update; the wrap bit distinguishes full from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since empty masks them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/mult_job_sequencer.sv
// Job feeder / result collector for the 6-bit signed shift-add multiplier.
// Operand pairs are queued in mult_seq_fifo, launched one at a time with a
// START_CYCLES-long mult_start pulse, and the product is captured into a
// single-entry output register.
//
// Optional feature macro: MULT_SEQ_WATCHDOG_EN. When defined, a WAIT-state
// watchdog aborts a job after TIMEOUT cycles without mult_done and reports
// it with out_err=1 and out_result=0. When undefined, WAIT waits forever
// and out_err is constant 0.
//
// Handshake rules (both ports): a transfer happens on a rising clk edge
// where valid and ready are both high. in_ready depends only on FIFO
// fullness, never on in_valid. out_valid, once high, stays high with
// out_result/out_err stable until the edge where out_ready is also high.
module mult_job_sequencer
  import mult_seq_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int START_CYCLES = DEF_START_CYCLES,
  parameter int TIMEOUT      = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_x,
  input  logic [OP_W-1:0]   in_y,
  output logic              mult_start,
  output logic [OP_W-1:0]   mult_x,
  output logic [OP_W-1:0]   mult_y,
  input  logic              mult_done,
  input  logic [PROD_W-1:0] mult_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] out_result,
  output logic              out_err
);

  // Phase counter counts down from START_CYCLES-1 to 0 while in START.
  localparam int SC_W = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
  localparam logic [SC_W-1:0] PHASE_LOAD = SC_W'(START_CYCLES - 1);

  // Elaboration-time parameter sanity checks.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("mult_job_sequencer: DEPTH must be a power of two >= 2");
  end
  if (START_CYCLES < 1) begin : g_bad_start
    $error("mult_job_sequencer: START_CYCLES must be >= 1");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("mult_job_sequencer: TIMEOUT must be >= 1");
  end

  seq_state_t      state;
  logic [SC_W-1:0] phase_cnt;
  job_t            in_job;
  job_t            head_job;
  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic            launch;
  logic            slot_free;

  assign in_job    = pack_job(in_x, in_y);
  assign in_ready  = !fifo_full;
  assign push      = in_valid && in_ready;
  // The output slot is free when empty or being drained this very edge.
  assign slot_free = !out_valid || out_ready;
  assign launch    = (state == IDLE) && !fifo_empty && slot_free;

  mult_seq_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(job_t))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (in_job),
    .pop   (launch),
    .rdata (head_job),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef MULT_SEQ_WATCHDOG_EN
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] wd_cnt;
  logic            err_q;

  assign out_err = err_q;
`else
  assign out_err = 1'b0;
`endif

  // Sequencer FSM plus output register: launch, start pulse, wait, capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      phase_cnt  <= '0;
      mult_start <= 1'b0;
      mult_x     <= '0;
      mult_y     <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
`ifdef MULT_SEQ_WATCHDOG_EN
      wd_cnt     <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      // Consumer drain; a capture below in the same cycle overrides it.
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
`ifdef MULT_SEQ_WATCHDOG_EN
        err_q     <= 1'b0;
`endif
      end

      case (state)
        IDLE: begin
          if (launch) begin
            mult_x     <= head_job.x;
            mult_y     <= head_job.y;
            mult_start <= 1'b1;
            phase_cnt  <= PHASE_LOAD;
            state      <= START;
          end
        end

        // mult_done is deliberately ignored here: a level done left over
        // from the previous job must not be mistaken for this job's.
        START: begin
          if (phase_cnt == '0) begin
            mult_start <= 1'b0;
            state      <= WAIT;
`ifdef MULT_SEQ_WATCHDOG_EN
            wd_cnt     <= '0;
`endif
          end else begin
            phase_cnt <= phase_cnt - 1'b1;
          end
        end

        WAIT: begin
          if (mult_done) begin
            out_result <= mult_result;
            out_valid  <= 1'b1;
`ifdef MULT_SEQ_WATCHDOG_EN
            err_q      <= 1'b0;
`endif
            state      <= IDLE;
          end
`ifdef MULT_SEQ_WATCHDOG_EN
          else if (wd_cnt == WD_LAST) begin
            out_result <= '0;
            out_valid  <= 1'b1;
            err_q      <= 1'b1;
            state      <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end

        default: begin
          mult_start <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_job_sequencer.sv
// Testbench for mult_job_sequencer. A behavioural multiplier responds to
// mult_start; a scoreboard checks every delivered result against products
// computed from the pushed operands.
module tb_mult_job_sequencer;

  localparam int S     = 2;
  localparam int T     = 64;
  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_x;
  logic [5:0]  in_y;
  logic        mult_start;
  logic [5:0]  mult_x;
  logic [5:0]  mult_y;
  logic        mult_done;
  logic [11:0] mult_result;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_result;
  logic        out_err;

  int total;
  int bad;
  int cyc;
  int got_cnt;
  int launch_cnt;
  int mode;          // 0 real multiplier, 1 done stuck high, 2 never done
  int lat_cnt;
  int ma, mb, mp;
  logic        start_prev;
  logic        valid_prev;
  logic [12:0] last_got;
  logic [12:0] exp_q[$];
  int          start_rise_q[$];
  int          valid_rise_q[$];
  bit          rr_en;

  mult_job_sequencer #(
    .DEPTH(DEPTH), .START_CYCLES(S), .TIMEOUT(T)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
    .mult_start(mult_start), .mult_x(mult_x), .mult_y(mult_y),
    .mult_done(mult_done), .mult_result(mult_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_err(out_err)
  );

  // ---------------- clock / reset block ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Global time limit so the run always ends.
  initial begin
    #3000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "time limit");
  end

  // ---------------- reference arithmetic ----------------
  function automatic logic [11:0] ref_prod(input logic [5:0] x, input logic [5:0] y);
    int a, b, p;
    a = $signed(x);
    b = $signed(y);
    p = a * b;
    return p[11:0];
  endfunction

  // Behavioural multiplier: done is a level that drops when start is seen
  // and rises after a random latency with the product of the held operands.
  always @(negedge clk) begin
    ma = $signed(mult_x);
    mb = $signed(mult_y);
    mp = ma * mb;
    if (rst) begin
      mult_done   = 1'b0;
      mult_result = '0;
      lat_cnt     = 0;
    end else if (mode == 1) begin
      mult_done   = 1'b1;
      mult_result = mp[11:0];
    end else if (mult_start) begin
      mult_done = 1'b0;
      lat_cnt   = $urandom_range(1, 6);
    end else if (mode == 0 && lat_cnt > 0) begin
      lat_cnt = lat_cnt - 1;
      if (lat_cnt == 0) begin
        mult_done   = 1'b1;
        mult_result = mp[11:0];
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected got=%h exp=none", {out_err, out_result});
        end else begin
          logic [12:0] e;
          e = exp_q.pop_front();
          if ({out_err, out_result} !== e) begin
            bad++;
            $display("FAIL sb_result got=%h exp=%h", {out_err, out_result}, e);
          end
        end
        last_got = {out_err, out_result};
        got_cnt++;
      end
      if (mult_start && !start_prev) begin
        launch_cnt++;
        start_rise_q.push_back(cyc);
      end
      if (out_valid && !valid_prev) valid_rise_q.push_back(cyc);
    end
    start_prev = rst ? 1'b0 : mult_start;
    valid_prev = rst ? 1'b0 : out_valid;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_job(input logic [5:0] x, input logic [5:0] y);
    bit ok, acc;
    ok = 0;
    in_x = x;
    in_y = y;
    in_valid = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) ok = 1;
    end
    in_valid = 1'b0;
    if (ok) exp_q.push_back({1'b0, ref_prod(x, y)});
    else begin
      total++;
      bad++;
      $display("FAIL push_timeout got=not_accepted exp=accepted");
    end
  endtask

  task automatic wait_got(input int target, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (got_cnt >= target) begin
        ok = 1;
        break;
      end
      tick(1);
    end
    if (got_cnt >= target) ok = 1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    @(negedge clk);
    total += 7;
    if (in_ready !== 1'b1)    begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    if (out_valid !== 1'b0)   begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    if (out_err !== 1'b0)     begin bad++; $display("FAIL rst_out_err got=%b exp=0", out_err); end
    if (out_result !== 12'h0) begin bad++; $display("FAIL rst_out_result got=%h exp=000", out_result); end
    if (mult_start !== 1'b0)  begin bad++; $display("FAIL rst_mult_start got=%b exp=0", mult_start); end
    if (mult_x !== 6'h0)      begin bad++; $display("FAIL rst_mult_x got=%h exp=00", mult_x); end
    if (mult_y !== 6'h0)      begin bad++; $display("FAIL rst_mult_y got=%h exp=00", mult_y); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single;
    int base;
    bit ok;
    base = got_cnt;
    mode = 0;
    out_ready = 1'b1;
    push_job(6'h30, 6'h05);                  // -16 * 5
    wait_got(base + 1, 100, ok);
    total += 2;
    if (!ok) begin bad++; $display("FAIL single_wait got=%0d exp=%0d", got_cnt - base, 1); end
    if (last_got !== 13'h0FB0) begin bad++; $display("FAIL single_value got=%h exp=0fb0", last_got); end
  endtask

  task automatic test_back_to_back;
    int base, sb, vb;
    bit ok;
    base = got_cnt;
    sb = start_rise_q.size();
    vb = valid_rise_q.size();
    push_job(6'h27, 6'h3C);                  // -25 * -4 = 100
    push_job(6'h1F, 6'h1F);                  // 31 * 31 = 961
    wait_got(base + 2, 200, ok);
    tick(2);
    total += 4;
    if (!ok) begin bad++; $display("FAIL b2b_wait got=%0d exp=2", got_cnt - base); end
    if (last_got !== 13'h03C1) begin bad++; $display("FAIL b2b_last got=%h exp=03c1", last_got); end
    if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_drain got=%0d exp=0", exp_q.size()); end
    if (start_rise_q.size() < sb + 2 || valid_rise_q.size() < vb + 1) begin
      bad++;
      $display("FAIL b2b_gap got=missing_events exp=present");
    end else if (start_rise_q[sb + 1] - valid_rise_q[vb] < 1) begin
      bad++;
      $display("FAIL b2b_gap got=%0d exp=>=1", start_rise_q[sb + 1] - valid_rise_q[vb]);
    end
  endtask

  task automatic test_backpressure;
    int base, bl;
    bit ok;
    base = got_cnt;
    bl = launch_cnt;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      push_job(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
    @(negedge clk);
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full got=%b exp=0", in_ready); end
    @(posedge clk);
    #1;
    tick(30);
    total += 3;
    if (launch_cnt - bl != 1) begin bad++; $display("FAIL bp_launches got=%0d exp=1", launch_cnt - bl); end
    if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_held got=%b exp=1", out_valid); end
    if (got_cnt != base) begin bad++; $display("FAIL bp_no_drain got=%0d exp=0", got_cnt - base); end
    out_ready = 1'b1;
    push_job(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
    wait_got(base + 6, 400, ok);
    tick(2);
    total += 3;
    if (!ok) begin bad++; $display("FAIL bp_wait got=%0d exp=6", got_cnt - base); end
    if (exp_q.size() != 0) begin bad++; $display("FAIL bp_drain got=%0d exp=0", exp_q.size()); end
    if (launch_cnt - bl != 6) begin bad++; $display("FAIL bp_total_launch got=%0d exp=6", launch_cnt - bl); end
  endtask

  task automatic test_random;
    int base;
    bit ok;
    base = got_cnt;
    rr_en = 1;
    fork
      begin
        while (rr_en) begin
          out_ready = ($urandom_range(0, 2) != 0);
          @(posedge clk);
          #1;
        end
      end
    join_none
    for (int i = 0; i < 16; i++) begin
      push_job(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
      tick($urandom_range(0, 3));
    end
    rr_en = 0;
    tick(2);
    out_ready = 1'b1;
    wait_got(base + 16, 600, ok);
    tick(2);
    total += 2;
    if (!ok) begin bad++; $display("FAIL rand_wait got=%0d exp=16", got_cnt - base); end
    if (exp_q.size() != 0) begin bad++; $display("FAIL rand_drain got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_stale_done;
    int base;
    logic [5:0] x, y;
    base = got_cnt;
    out_ready = 1'b1;
    mode = 1;
    tick(2);
    x = 6'($urandom_range(0, 63));
    y = 6'($urandom_range(0, 63));
    push_job(x, y);                          // now in cycle 0 of this job
    for (int k = 1; k <= S + 2; k++) begin
      @(posedge clk);
      @(negedge clk);
      total += 2;
      if (mult_start !== (k <= S)) begin
        bad++;
        $display("FAIL stale_start_c%0d got=%b exp=%b", k, mult_start, (k <= S));
      end
      if (out_valid !== (k == S + 2)) begin
        bad++;
        $display("FAIL stale_valid_c%0d got=%b exp=%b", k, out_valid, (k == S + 2));
      end
    end
    @(posedge clk);
    #1;
    mode = 0;
    tick(2);
    total += 2;
    if (got_cnt - base != 1) begin bad++; $display("FAIL stale_count got=%0d exp=1", got_cnt - base); end
    if (last_got !== {1'b0, ref_prod(x, y)}) begin
      bad++;
      $display("FAIL stale_value got=%h exp=%h", last_got, {1'b0, ref_prod(x, y)});
    end
  endtask

  task automatic test_reset_mid;
    int base, bl;
    out_ready = 1'b1;
    mode = 2;
    for (int i = 0; i < 3; i++)
      push_job(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
    tick(8);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total += 6;
    if (out_valid !== 1'b0)   begin bad++; $display("FAIL mid_out_valid got=%b exp=0", out_valid); end
    if (out_result !== 12'h0) begin bad++; $display("FAIL mid_out_result got=%h exp=000", out_result); end
    if (mult_start !== 1'b0)  begin bad++; $display("FAIL mid_mult_start got=%b exp=0", mult_start); end
    if ({mult_x, mult_y} !== 12'h0) begin bad++; $display("FAIL mid_mult_xy got=%h exp=000", {mult_x, mult_y}); end
    if (out_err !== 1'b0)     begin bad++; $display("FAIL mid_out_err got=%b exp=0", out_err); end
    if (in_ready !== 1'b1)    begin bad++; $display("FAIL mid_in_ready got=%b exp=1", in_ready); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    base = got_cnt;
    bl = launch_cnt;
    mode = 0;
    tick(40);
    total += 2;
    if (got_cnt != base) begin bad++; $display("FAIL mid_no_result got=%0d exp=0", got_cnt - base); end
    if (launch_cnt != bl) begin bad++; $display("FAIL mid_no_launch got=%0d exp=0", launch_cnt - bl); end
  endtask

`ifdef MULT_SEQ_WATCHDOG_EN
  task automatic test_no_done;
    int base, a_cyc, rise;
    logic        err_at;
    logic [11:0] res_at;
    logic [5:0]  bx, by;
    bit ok;
    base = got_cnt;
    out_ready = 1'b1;
    mode = 2;
    push_job(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
    a_cyc = cyc;
    exp_q[exp_q.size() - 1] = 13'h1000;      // aborted job: err=1, result=0
    bx = 6'($urandom_range(0, 63));
    by = 6'($urandom_range(0, 63));
    push_job(bx, by);
    rise = -1;
    err_at = 1'b0;
    res_at = 12'hFFF;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (out_valid) begin
        rise = cyc;
        err_at = out_err;
        res_at = out_result;
        break;
      end
    end
    @(posedge clk);
    #1;
    mode = 0;
    total += 3;
    if (rise - a_cyc != S + 1 + T) begin bad++; $display("FAIL wd_timing got=%0d exp=%0d", rise - a_cyc, S + 1 + T); end
    if (err_at !== 1'b1) begin bad++; $display("FAIL wd_err got=%b exp=1", err_at); end
    if (res_at !== 12'h0) begin bad++; $display("FAIL wd_result got=%h exp=000", res_at); end
    wait_got(base + 2, 200, ok);
    tick(2);
    total += 3;
    if (!ok) begin bad++; $display("FAIL wd_next_wait got=%0d exp=2", got_cnt - base); end
    if (last_got !== {1'b0, ref_prod(bx, by)}) begin
      bad++;
      $display("FAIL wd_next_value got=%h exp=%h", last_got, {1'b0, ref_prod(bx, by)});
    end
    if (exp_q.size() != 0) begin bad++; $display("FAIL wd_drain got=%0d exp=0", exp_q.size()); end
  endtask
`else
  task automatic test_no_done;
    int base;
    bit ok;
    base = got_cnt;
    out_ready = 1'b1;
    mode = 2;
    push_job(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
    tick(150);
    total += 3;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL nd_valid got=%b exp=0", out_valid); end
    if (out_err !== 1'b0) begin bad++; $display("FAIL nd_err got=%b exp=0", out_err); end
    if (got_cnt != base) begin bad++; $display("FAIL nd_count got=%0d exp=0", got_cnt - base); end
    mode = 0;
    wait_got(base + 1, 100, ok);
    tick(2);
    total += 3;
    if (!ok) begin bad++; $display("FAIL nd_resume got=%0d exp=1", got_cnt - base); end
    if (last_got[12] !== 1'b0) begin bad++; $display("FAIL nd_err_flag got=%b exp=0", last_got[12]); end
    if (exp_q.size() != 0) begin bad++; $display("FAIL nd_drain got=%0d exp=0", exp_q.size()); end
  endtask
`endif

  // ---------------- main sequence + final report ----------------
  initial begin
    total = 0;
    bad = 0;
    cyc = 0;
    got_cnt = 0;
    launch_cnt = 0;
    mode = 0;
    lat_cnt = 0;
    start_prev = 1'b0;
    valid_prev = 1'b0;
    last_got = '0;
    rr_en = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_x = '0;
    in_y = '0;
    out_ready = 1'b1;
    mult_done = 1'b0;
    mult_result = '0;

    test_reset;
    test_single;
    test_back_to_back;
    test_backpressure;
    test_random;
    test_stale_done;
    test_reset_mid;
    test_no_done;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
